// File: rtl/div_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// div_scheduler_pkg
// Shared definitions for the divider scheduler: operation encoding, FSM state
// encoding and small decode helpers used by the interface, the scheduler and
// the testbench.
// -----------------------------------------------------------------------------
package div_scheduler_pkg;

    // Operation encoding on issue_op. Bit 0 selects unsigned, bit 1 selects
    // remainder instead of quotient.
    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } op_e;

    // State codes kept as plain constants so legacy code can compare against
    // them directly; the enum below wraps the same values.
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_RESULT = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = S_IDLE,
        START  = S_START,
        RUN    = S_RUN,
        RESULT = S_RESULT,
        DRAIN  = S_DRAIN
    } state_e;

    function automatic logic op_is_unsigned(input op_e op);
        return op[0];
    endfunction

    function automatic logic op_is_rem(input op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/div_scheduler_if.sv
// -----------------------------------------------------------------------------
// div_scheduler_if
// Request/writeback bus between an issuing pipeline and the divider scheduler.
//   issue_valid/issue_ready  request handshake
//   issue_op/rs1/rs2/id      operation, dividend, divisor, tag
//   flush                    discard anything not yet written back
//   wb_valid/wb_ack          writeback handshake
//   wb_data/wb_id            result and its tag
// master = requester side, slave = scheduler side.
// -----------------------------------------------------------------------------
interface div_scheduler_if
    import div_scheduler_pkg::*;
#(
    parameter int DIV_WIDTH = 32,
    parameter int ID_W      = 3
) ();

    logic                 issue_valid;
    logic                 issue_ready;
    op_e                  issue_op;
    logic [DIV_WIDTH-1:0] issue_rs1;
    logic [DIV_WIDTH-1:0] issue_rs2;
    logic [ID_W-1:0]      issue_id;
    logic                 flush;
    logic                 wb_valid;
    logic                 wb_ack;
    logic [DIV_WIDTH-1:0] wb_data;
    logic [ID_W-1:0]      wb_id;

    modport master (
        output issue_valid, issue_op, issue_rs1, issue_rs2, issue_id, flush, wb_ack,
        input  issue_ready, wb_valid, wb_data, wb_id
    );

    modport slave (
        input  issue_valid, issue_op, issue_rs1, issue_rs2, issue_id, flush, wb_ack,
        output issue_ready, wb_valid, wb_data, wb_id
    );

endinterface

// File: rtl/div_scheduler_clz.sv
// -----------------------------------------------------------------------------
// clz
// Count of leading zeros of a WIDTH-bit value. A zero input saturates to
// WIDTH-1 (the same code as an input of 1) so the result fits in
// clog2(WIDTH) bits.
//   i_value  value to inspect
//   o_count  number of leading zeros, saturated at WIDTH-1
// -----------------------------------------------------------------------------
module clz #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]         i_value,
    output logic [$clog2(WIDTH)-1:0] o_count
);

    localparam int CW = $clog2(WIDTH);

    // NOTE: o_count gets a default before the loop so every path assigns it
    // and no latch is inferred.
    always_comb begin
        o_count = CW'(WIDTH - 1);
        // Scanning upwards, the highest set bit is the last one to write.
        for (int i = 0; i < WIDTH; i++) begin
            if (i_value[i]) begin
                o_count = CW'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/div_scheduler.sv
// -----------------------------------------------------------------------------
// div_scheduler
// Front end for an iterative divider core. Accepts DIV/DIVU/REM/REMU requests,
// short-circuits divide-by-zero and repeats of the last core-computed operand
// pair, otherwise launches the core on unsigned magnitudes and applies sign
// correction on the way back.
//   clk, rst              clock, synchronous active-high reset
//   bus (slave)           issue / flush / writeback handshake
//   div_start             one-cycle launch pulse to the core
//   div_dividend/divisor  unsigned magnitudes, stable until div_done
//   div_*_CLZ             leading-zero counts of those magnitudes
//   div_done              core completion (may coincide with div_start)
//   div_quotient/remainder unsigned core results
// -----------------------------------------------------------------------------
module div_scheduler
    import div_scheduler_pkg::*;
#(
    parameter int DIV_WIDTH = 32,
    parameter int ID_W      = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    div_scheduler_if.slave               bus,
    output logic                         div_start,
    output logic [DIV_WIDTH-1:0]         div_dividend,
    output logic [DIV_WIDTH-1:0]         div_divisor,
    output logic [$clog2(DIV_WIDTH)-1:0] div_dividend_CLZ,
    output logic [$clog2(DIV_WIDTH)-1:0] div_divisor_CLZ,
    input  logic                         div_done,
    input  logic [DIV_WIDTH-1:0]         div_quotient,
    input  logic [DIV_WIDTH-1:0]         div_remainder
);

    state_e               r_state;
    state_e               w_next_state;

    // Request held while in flight.
    op_e                  r_op;
    logic [ID_W-1:0]      r_id;
    logic [DIV_WIDTH-1:0] r_rs1;
    logic [DIV_WIDTH-1:0] r_rs2;
    logic [DIV_WIDTH-1:0] r_mag_a;
    logic [DIV_WIDTH-1:0] r_mag_b;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic [DIV_WIDTH-1:0] r_wb_data;

    // Single-entry cache of the last core-computed operand pair.
    logic                 r_reuse_valid;
    logic                 r_reuse_uns;
    logic [DIV_WIDTH-1:0] r_reuse_rs1;
    logic [DIV_WIDTH-1:0] r_reuse_rs2;
    logic [DIV_WIDTH-1:0] r_reuse_q;
    logic [DIV_WIDTH-1:0] r_reuse_r;

    logic                 w_in_uns;
    logic                 w_in_rem;
    logic                 w_rs1_neg;
    logic                 w_rs2_neg;
    logic [DIV_WIDTH-1:0] w_mag_a;
    logic [DIV_WIDTH-1:0] w_mag_b;
    logic                 w_div_zero;
    logic                 w_reuse_hit;
    logic                 w_accept;
    logic                 w_core_busy;
    logic                 w_core_capture;
    logic                 w_reuse_kill;

    // Selects quotient or remainder and restores the sign. For min / -1 the
    // quotient magnitude is 2^(W-1) with no negation, which reads back as min.
    function automatic logic [DIV_WIDTH-1:0] fix_sign(
        input logic                 is_rem,
        input logic                 neg_q,
        input logic                 neg_r,
        input logic [DIV_WIDTH-1:0] q,
        input logic [DIV_WIDTH-1:0] r
    );
        if (is_rem) begin
            return neg_r ? -r : r;
        end
        return neg_q ? -q : q;
    endfunction

    // ---------------------------------------------------------------- decode
    assign w_in_uns    = op_is_unsigned(bus.issue_op);
    assign w_in_rem    = op_is_rem(bus.issue_op);
    assign w_rs1_neg   = ~w_in_uns & bus.issue_rs1[DIV_WIDTH-1];
    assign w_rs2_neg   = ~w_in_uns & bus.issue_rs2[DIV_WIDTH-1];
    assign w_mag_a     = w_rs1_neg ? -bus.issue_rs1 : bus.issue_rs1;
    assign w_mag_b     = w_rs2_neg ? -bus.issue_rs2 : bus.issue_rs2;
    assign w_div_zero  = (bus.issue_rs2 == '0);
    assign w_reuse_hit = r_reuse_valid
                       && (bus.issue_rs1 == r_reuse_rs1)
                       && (bus.issue_rs2 == r_reuse_rs2)
                       && (w_in_uns == r_reuse_uns);

    assign w_accept       = bus.issue_valid & bus.issue_ready;
    assign w_core_busy    = (r_state == START) || (r_state == RUN);
    // A flush racing with div_done discards the result like DRAIN would.
    assign w_core_capture = w_core_busy & div_done & ~bus.flush;
    assign w_reuse_kill   = div_done & ((r_state == DRAIN) | (w_core_busy & bus.flush));

    // ------------------------------------------------------------------- FSM
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = (w_div_zero || w_reuse_hit) ? RESULT : START;
                end
            end
            START, RUN: begin
                if (div_done) begin
                    w_next_state = bus.flush ? IDLE : RESULT;
                end else begin
                    w_next_state = bus.flush ? DRAIN : RUN;
                end
            end
            DRAIN: begin
                if (div_done) begin
                    w_next_state = IDLE;
                end
            end
            RESULT: begin
                if (bus.flush || bus.wb_ack) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_reuse_valid <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_core_capture) begin
                r_reuse_valid <= 1'b1;
            end else if (w_reuse_kill) begin
                r_reuse_valid <= 1'b0;
            end
        end
    end

    // NOTE: datapath registers carry no reset; they are only consumed once the
    // reset-cleared state and valid bits say they were written.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op    <= bus.issue_op;
            r_id    <= bus.issue_id;
            r_rs1   <= bus.issue_rs1;
            r_rs2   <= bus.issue_rs2;
            r_mag_a <= w_mag_a;
            r_mag_b <= w_mag_b;
            r_neg_q <= w_rs1_neg ^ w_rs2_neg;
            r_neg_r <= w_rs1_neg;
            if (w_div_zero) begin
                r_wb_data <= w_in_rem ? bus.issue_rs1 : '1;
            end else if (w_reuse_hit) begin
                r_wb_data <= fix_sign(w_in_rem, w_rs1_neg ^ w_rs2_neg, w_rs1_neg,
                                      r_reuse_q, r_reuse_r);
            end
        end
        if (w_core_capture) begin
            r_wb_data   <= fix_sign(op_is_rem(r_op), r_neg_q, r_neg_r,
                                    div_quotient, div_remainder);
            r_reuse_rs1 <= r_rs1;
            r_reuse_rs2 <= r_rs2;
            r_reuse_uns <= op_is_unsigned(r_op);
            r_reuse_q   <= div_quotient;
            r_reuse_r   <= div_remainder;
        end
    end

    // --------------------------------------------------------------- outputs
    assign bus.issue_ready = (r_state == IDLE) & ~rst & ~bus.flush;
    assign bus.wb_valid    = (r_state == RESULT);
    assign bus.wb_data     = r_wb_data;
    assign bus.wb_id       = r_id;

    assign div_start    = (r_state == START);
    assign div_dividend = r_mag_a;
    assign div_divisor  = r_mag_b;

    clz #(.WIDTH(DIV_WIDTH)) u_clz_dividend (
        .i_value (r_mag_a),
        .o_count (div_dividend_CLZ)
    );

    clz #(.WIDTH(DIV_WIDTH)) u_clz_divisor (
        .i_value (r_mag_b),
        .o_count (div_divisor_CLZ)
    );

endmodule
